// File: rtl/orb_frame_rx_if.sv
// Serial-in / word-out bundle for the orbit frame receiver.
// The master drives the bit stream; the slave (receiver) returns framed words.
interface orb_frame_rx_if #(
    parameter int WORD_W = 12,
    parameter int ADDR_W = 11
);
    logic              bit_en;
    logic              serial_in;
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic [ADDR_W-1:0] word_addr;
    logic              frame_start;
    logic              locked;
    logic [15:0]       frame_cnt;

    modport master (
        output bit_en, serial_in,
        input  word_data, word_valid, word_addr, frame_start, locked, frame_cnt
    );

    modport slave (
        input  bit_en, serial_in,
        output word_data, word_valid, word_addr, frame_start, locked, frame_cnt
    );
endinterface

// File: rtl/orb_frame_rx.sv
// Orbit serial frame receiver: sliding marker search, confirmation over CONFIRM
// frames, then word/frame delivery while locked, dropping lock after MISS_MAX misses.
module orb_frame_rx #(
    parameter int                WORD_W      = 12,
    parameter int                FRAME_WORDS = 2048,
    parameter int                ADDR_W      = 11,
    parameter logic [WORD_W-1:0] SYNC_WORD   = 12'hF1B,
    parameter int                CONFIRM     = 2,
    parameter int                MISS_MAX    = 3
) (
    input logic           clk,
    input logic           reset,
    orb_frame_rx_if.slave bus
);
    localparam int SCNT_W = $clog2(WORD_W + 1);
    localparam int BCNT_W = $clog2(WORD_W);
    localparam int HIT_W  = $clog2(CONFIRM + 1);
    localparam int MISS_W = $clog2(MISS_MAX + 1);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCK} state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   sr_q, sr_d;
    logic [SCNT_W-1:0]   scnt_q, scnt_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [ADDR_W-1:0]   widx_q, widx_d;
    logic [HIT_W-1:0]    hit_q, hit_d;
    logic [MISS_W-1:0]   miss_q, miss_d;
    logic [15:0]         fcnt_q, fcnt_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic                wvalid_q, wvalid_d;
    logic                fstart_q, fstart_d;
    logic                locked_q, locked_d;
    logic                word_done;
    logic                is_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SEARCH;
            sr_q     <= '0;
            scnt_q   <= '0;
            bcnt_q   <= '0;
            widx_q   <= '0;
            hit_q    <= '0;
            miss_q   <= '0;
            fcnt_q   <= '0;
            wdata_q  <= '0;
            waddr_q  <= '0;
            wvalid_q <= 1'b0;
            fstart_q <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            scnt_q   <= scnt_d;
            bcnt_q   <= bcnt_d;
            widx_q   <= widx_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            fcnt_q   <= fcnt_d;
            wdata_q  <= wdata_d;
            waddr_q  <= waddr_d;
            wvalid_q <= wvalid_d;
            fstart_q <= fstart_d;
            locked_q <= locked_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        scnt_d    = scnt_q;
        bcnt_d    = bcnt_q;
        widx_d    = widx_q;
        hit_d     = hit_q;
        miss_d    = miss_q;
        fcnt_d    = fcnt_q;
        wdata_d   = wdata_q;
        waddr_d   = waddr_q;
        wvalid_d  = 1'b0;
        fstart_d  = 1'b0;
        word_done = 1'b0;
        is_hit    = 1'b0;

        if (bus.bit_en) begin
            sr_d = {sr_q[WORD_W-2:0], bus.serial_in};
            if (state_q == SEARCH) begin
                // scnt saturates at WORD_W; the current bit completes a full window at WORD_W-1
                if (scnt_q != SCNT_W'(WORD_W))
                    scnt_d = scnt_q + 1'b1;
                if (scnt_q >= SCNT_W'(WORD_W - 1) && sr_d == SYNC_WORD) begin
                    state_d = CHECK;
                    bcnt_d  = '0;
                    widx_d  = ADDR_W'(1);
                    hit_d   = HIT_W'(1);
                end
            end else begin
                word_done = (bcnt_q == BCNT_W'(WORD_W - 1));
                bcnt_d    = word_done ? '0 : bcnt_q + 1'b1;
                if (word_done) begin
                    widx_d = (widx_q == ADDR_W'(FRAME_WORDS - 1)) ? '0 : widx_q + 1'b1;
                    is_hit = (sr_d == SYNC_WORD);
                    if (widx_q == '0) begin
                        if (state_q == CHECK) begin
                            if (is_hit) begin
                                hit_d = hit_q + 1'b1;
                                if (hit_d == HIT_W'(CONFIRM)) begin
                                    state_d = LOCK;
                                    miss_d  = '0;
                                end
                            end else begin
                                state_d = SEARCH;
                                scnt_d  = '0;
                            end
                        end else if (is_hit) begin
                            miss_d = '0;
                            fcnt_d = fcnt_q + 1'b1;
                        end else begin
                            miss_d = miss_q + 1'b1;
                            if (miss_d == MISS_W'(MISS_MAX)) begin
                                state_d = SEARCH;
                                scnt_d  = '0;
                            end
                        end
                    end
                    // Deliver the confirming marker and the lock-dropping word as well
                    if (state_q == LOCK || state_d == LOCK) begin
                        wvalid_d = 1'b1;
                        wdata_d  = sr_d;
                        waddr_d  = widx_q;
                        fstart_d = (widx_q == '0);
                    end
                end
            end
        end

        locked_d = (state_d == LOCK);
    end

    assign bus.word_data   = wdata_q;
    assign bus.word_valid  = wvalid_q;
    assign bus.word_addr   = waddr_q;
    assign bus.frame_start = fstart_q;
    assign bus.locked      = locked_q;
    assign bus.frame_cnt   = fcnt_q;
endmodule
